data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with a one-entry posted write buffer and sticky range error
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_enable,
  input  logic [31:0] mem_read_address,
  output logic [31:0] mem_read_data,
  input  logic        mem_write_enable,
  input  logic [31:0] mem_write_address,
  input  logic [3:0]  mem_write_select,
  input  logic [31:0] mem_write_data,
  output logic        mem_error,
  output logic [31:0] mem_error_address
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage array; deliberately not reset, contents undefined until written.
  logic [31:0] mem_array [0:DEPTH-1];

  // One-entry posted write buffer.
  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_index;
  logic [3:0]            buf_select;
  logic [31:0]           buf_data;

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [ADDR_WIDTH-1:0] rd_index;
  logic [ADDR_WIDTH-1:0] wr_index;
  logic                  wr_accept;
  logic                  rd_oor;
  logic                  wr_oor;

  // Byte-address decode: low two bits never select lanes, upper bits must be zero.
  assign rd_in_range = ((mem_read_address >> (ADDR_WIDTH + 2)) == 32'd0);
  assign wr_in_range = ((mem_write_address >> (ADDR_WIDTH + 2)) == 32'd0);
  assign rd_index    = mem_read_address[ADDR_WIDTH+1:2];
  assign wr_index    = mem_write_address[ADDR_WIDTH+1:2];

  assign wr_accept = mem_write_enable && wr_in_range && (mem_write_select != 4'b0000);
  assign rd_oor    = mem_read_enable && !rd_in_range;
  assign wr_oor    = mem_write_enable && !wr_in_range;

  // Load the buffer with each accepted write; an unreloaded entry lives for one edge only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid  <= 1'b0;
      buf_index  <= '0;
      buf_select <= 4'b0000;
      buf_data   <= 32'd0;
    end else begin
      buf_valid <= wr_accept;
      if (wr_accept) begin
        buf_index  <= wr_index;
        buf_select <= mem_write_select;
        buf_data   <= mem_write_data;
      end
    end
  end

  // Drain the buffered entry into the array, only the enabled byte lanes.
  always_ff @(posedge clock) begin
    if (buf_valid) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (buf_select[lane]) begin
          mem_array[buf_index][8*lane +: 8] <= buf_data[8*lane +: 8];
        end
      end
    end
  end

  // Sticky error flag; first offending address kept, write address wins a tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_error         <= 1'b0;
      mem_error_address <= 32'd0;
    end else if (!mem_error && (rd_oor || wr_oor)) begin
      mem_error         <= 1'b1;
      mem_error_address <= wr_oor ? mem_write_address : mem_read_address;
    end
  end

  // Combinational read: array word with still-buffered lanes forwarded over it.
  always_comb begin
    mem_read_data = 32'd0;
    if (!reset && mem_read_enable && rd_in_range) begin
      mem_read_data = mem_array[rd_index];
      for (int lane = 0; lane < 4; lane++) begin
        if (buf_valid && (buf_index == rd_index) && buf_select[lane]) begin
          mem_read_data[8*lane +: 8] = buf_data[8*lane +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [3:0]  mem_write_select;
  logic [31:0] mem_write_data;
  logic        mem_error;
  logic [31:0] mem_error_address;

  int total;
  int bad;

  data_mem_responder #(.ADDR_WIDTH(10)) dut (
    .clock             (clock),
    .reset             (reset),
    .mem_read_enable   (mem_read_enable),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_select  (mem_write_select),
    .mem_write_data    (mem_write_data),
    .mem_error         (mem_error),
    .mem_error_address (mem_error_address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        re;
    logic [31:0] raddr;
    logic        we;
    logic [31:0] waddr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_ea;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic [31:0] raddr, input logic we,
                       input logic [31:0] waddr, input logic [3:0] sel, input logic [31:0] wdata);
    mem_read_enable   = re;
    mem_read_address  = raddr;
    mem_write_enable  = we;
    mem_write_address = waddr;
    mem_write_select  = sel;
    mem_write_data    = wdata;
  endtask

  task automatic add(input logic re, input logic [31:0] raddr, input logic we,
                     input logic [31:0] waddr, input logic [3:0] sel, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input logic [31:0] exp_ea);
    vec_t v;
    v.re = re; v.raddr = raddr; v.we = we; v.waddr = waddr; v.sel = sel; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_ea = exp_ea;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b1, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0);

    // Each vector: inputs applied at negedge, outputs checked 1ns later (pre-edge state).
    //   re  raddr         we  waddr         sel    wdata          exp_rd         err  ea
    add(0, 32'h0000_0000, 1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0000_0000, 0, 32'h0);        // 0
    add(1, 32'h0000_0010, 0, 32'h0,         4'h0, 32'h0,         32'h1122_3344, 0, 32'h0);        // 1 from buffer
    add(0, 32'h0000_0010, 0, 32'h0,         4'h0, 32'h0,         32'h0000_0000, 0, 32'h0);        // 2 re=0
    add(1, 32'h0000_0010, 0, 32'h0,         4'h0, 32'h0,         32'h1122_3344, 0, 32'h0);        // 3 from array
    add(1, 32'h0000_0010, 1, 32'h0000_0011, 4'h4, 32'hAAAA_AAAA, 32'h1122_3344, 0, 32'h0);        // 4 no same-cycle fwd
    add(1, 32'h0000_0010, 0, 32'h0,         4'h0, 32'h0,         32'h11AA_3344, 0, 32'h0);        // 5 lane fwd
    add(0, 32'h0,         1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'h0);        // 6
    add(1, 32'h0000_0020, 1, 32'h0000_0024, 4'hF, 32'h0BAD_F00D, 32'hDEAD_BEEF, 0, 32'h0);        // 7
    add(1, 32'h0000_0024, 0, 32'h0,         4'h0, 32'h0,         32'h0BAD_F00D, 0, 32'h0);        // 8
    add(1, 32'h0000_0020, 0, 32'h0,         4'h0, 32'h0,         32'hDEAD_BEEF, 0, 32'h0);        // 9
    add(1, 32'h0000_0024, 0, 32'h0,         4'h0, 32'h0,         32'h0BAD_F00D, 0, 32'h0);        // 10
    add(1, 32'h0000_0010, 0, 32'h0,         4'h0, 32'h0,         32'h11AA_3344, 0, 32'h0);        // 11
    add(0, 32'h0,         1, 32'h0000_0050, 4'hF, 32'h0102_0304, 32'h0000_0000, 0, 32'h0);        // 12
    add(1, 32'h0000_0050, 1, 32'h0000_0052, 4'h3, 32'hA0B0_C0D0, 32'h0102_0304, 0, 32'h0);        // 13
    add(1, 32'h0000_0050, 0, 32'h0,         4'h0, 32'h0,         32'h0102_C0D0, 0, 32'h0);        // 14 later wins
    add(1, 32'h0000_0050, 0, 32'h0,         4'h0, 32'h0,         32'h0102_C0D0, 0, 32'h0);        // 15
    add(0, 32'h0,         1, 32'h0000_0050, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 0, 32'h0);        // 16 sel 0
    add(1, 32'h0000_0050, 0, 32'h0,         4'h0, 32'h0,         32'h0102_C0D0, 0, 32'h0);        // 17
    add(0, 32'h0,         1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 0, 32'h0);        // 18
    add(0, 32'h0,         0, 32'h0,         4'h0, 32'h0,         32'h0000_0000, 0, 32'h0);        // 19
    add(1, 32'h0000_0040, 1, 32'h0000_0040, 4'hF, 32'h1234_5678, 32'hCAFE_F00D, 0, 32'h0);        // 20
    add(1, 32'h0000_0040, 0, 32'h0,         4'h0, 32'h0,         32'h1234_5678, 0, 32'h0);        // 21
    add(0, 32'h0,         1, 32'h0000_0FFC, 4'hF, 32'h7777_8888, 32'h0000_0000, 0, 32'h0);        // 22 top word
    add(1, 32'h0000_0FFC, 0, 32'h0,         4'h0, 32'h0,         32'h7777_8888, 0, 32'h0);        // 23
    add(0, 32'h0,         1, 32'h0000_0030, 4'hF, 32'h1357_9BDF, 32'h0000_0000, 0, 32'h0);        // 24
    add(1, 32'h0000_1000, 0, 32'h0,         4'h0, 32'h0,         32'h0000_0000, 0, 32'h0);        // 25 oor read
    add(0, 32'h0,         0, 32'h0,         4'h0, 32'h0,         32'h0000_0000, 1, 32'h0000_1000); // 26
    add(0, 32'h0,         1, 32'h0000_2010, 4'hF, 32'h9999_9999, 32'h0000_0000, 1, 32'h0000_1000); // 27 oor write
    add(1, 32'h0000_0010, 0, 32'h0,         4'h0, 32'h0,         32'h11AA_3344, 1, 32'h0000_1000); // 28 discarded
    add(1, 32'h0000_0030, 0, 32'h0,         4'h0, 32'h0,         32'h1357_9BDF, 1, 32'h0000_1000); // 29

    #2;
    check("reset_rd",  mem_read_data, 32'h0);
    check("reset_err", {31'd0, mem_error}, 32'h0);
    check("reset_ea",  mem_error_address, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].re, vecs[i].raddr, vecs[i].we, vecs[i].waddr, vecs[i].sel, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_rd", i),  mem_read_data, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), {31'd0, mem_error}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_ea", i),  mem_error_address, vecs[i].exp_ea);
    end

    // Posted write killed by reset before it drains.
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b1, 32'h30, 4'hF, 32'h5555_5555);
    @(negedge clock);
    drive(1'b1, 32'h30, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("pre_reset_fwd", mem_read_data, 32'h5555_5555);
    reset = 1'b1;
    #1;
    check("in_reset_rd",  mem_read_data, 32'h0);
    check("in_reset_err", {31'd0, mem_error}, 32'h0);
    check("in_reset_ea",  mem_error_address, 32'h0);
    @(negedge clock);
    drive(1'b1, 32'h30, 1'b1, 32'h34, 4'hF, 32'h2468_2468);
    #1;
    check("reset_write_ignored", {31'd0, dut.buf_valid}, 32'h0);
    reset = 1'b0;
    #1;
    check("post_reset_rd30", mem_read_data, 32'h1357_9BDF);
    check("post_reset_err",  {31'd0, mem_error}, 32'h0);
    @(negedge clock);
    drive(1'b1, 32'h34, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("first_write_after_reset", mem_read_data, 32'h2468_2468);

    // Read and write both out of range: write address is captured.
    @(negedge clock);
    drive(1'b1, 32'h0000_4000, 1'b1, 32'h0000_8000, 4'hF, 32'h1111_1111);
    #1;
    check("both_oor_rd", mem_read_data, 32'h0);
    @(negedge clock);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    check("both_oor_err", {31'd0, mem_error}, 32'h1);
    check("both_oor_ea",  mem_error_address, 32'h0000_8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
